// File: rtl/hdmi_packet_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_packet_scheduler
// Description : Picks the packet for each HDMI data-island slot (ACR, audio
//               sample, AVI InfoFrame, Audio InfoFrame or Null) and builds
//               audio sample packets from a stereo sample FIFO.
//               Define AUDIO_INFOFRAME_EN to schedule Audio InfoFrames.
// Revision    : 1.0 - initial release
// ============================================================================
module hdmi_packet_scheduler #(
  parameter int AUDIO_BIT_WIDTH = 16,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                       clk_pixel,
  input  logic                       reset_n,
  input  logic                       audio_sample_valid,
  input  logic [AUDIO_BIT_WIDTH-1:0] audio_sample_l,
  input  logic [AUDIO_BIT_WIDTH-1:0] audio_sample_r,
  input  logic                       acr_wrap,
  input  logic [23:0]                acr_header,
  input  logic [223:0]               acr_sub,
  input  logic [23:0]                avi_header,
  input  logic [223:0]               avi_sub,
  input  logic [23:0]                aif_header,
  input  logic [223:0]               aif_sub,
  input  logic                       video_field_end,
  input  logic                       packet_enable,
  output logic [23:0]                header,
  output logic [223:0]               sub,
  output logic [2:0]                 packet_type,
  output logic                       fifo_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] PT_NULL  = 3'd0;
  localparam logic [2:0] PT_ACR   = 3'd1;
  localparam logic [2:0] PT_AUDIO = 3'd2;
  localparam logic [2:0] PT_AVI   = 3'd3;
`ifdef AUDIO_INFOFRAME_EN
  localparam logic [2:0] PT_AIF   = 3'd4;
`endif

  logic [AUDIO_BIT_WIDTH-1:0] mem_l [FIFO_DEPTH];
  logic [AUDIO_BIT_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]           rd_ptr;
  logic [PTR_W-1:0]           wr_ptr;
  logic [CNT_W-1:0]           count;
  logic [7:0]                 frame;
  logic                       acr_wrap_q;
  logic                       acr_pend;
  logic                       avi_pend;
  logic                       aif_pend;

  logic                       sel_acr;
  logic                       sel_audio;
  logic                       sel_avi;
  logic                       sel_aif;
  logic [2:0]                 pop_n;
  logic                       push_ok;
  logic [23:0]                aud_header;
  logic [223:0]               aud_sub;
  logic [7:0]                 frame_next;
  logic [8:0]                 frame_sum;
  logic [7:0]                 fc;
  logic [PTR_W-1:0]           idx;
  logic [23:0]                l24;
  logic [23:0]                r24;
  logic [3:0]                 present;
  logic [3:0]                 bflag;

  function automatic logic [23:0] justify(input logic [AUDIO_BIT_WIDTH-1:0] s);
    logic [AUDIO_BIT_WIDTH+23:0] wide;
    wide = {s, 24'h000000};
    return wide[AUDIO_BIT_WIDTH+23 -: 24];
  endfunction

  // Priority arbitration on the state held before the packet_enable edge
  always_comb begin
    sel_acr   = 1'b0;
    sel_audio = 1'b0;
    sel_avi   = 1'b0;
    sel_aif   = 1'b0;
    if (packet_enable) begin
      if (acr_pend)                 sel_acr   = 1'b1;
      else if (count != '0)         sel_audio = 1'b1;
      else if (avi_pend)            sel_avi   = 1'b1;
      else if (aif_pend)            sel_aif   = 1'b1;
    end
  end

  always_comb begin
    pop_n = 3'd0;
    if (sel_audio)
      pop_n = (count >= CNT_W'(4)) ? 3'd4 : count[2:0];
    push_ok = audio_sample_valid &&
              ((count != CNT_W'(FIFO_DEPTH)) || (pop_n != 3'd0));
  end

  always_comb begin
    aud_sub = '0;
    present = 4'b0000;
    bflag   = 4'b0000;
    fc      = 8'd0;
    idx     = '0;
    l24     = 24'd0;
    r24     = 24'd0;
    for (int k = 0; k < 4; k++) begin
      fc = frame + 8'(k);
      if (fc >= 8'd192) fc = fc - 8'd192;
      if (3'(k) < pop_n) begin
        idx        = rd_ptr + PTR_W'(k);
        l24        = justify(mem_l[idx]);
        r24        = justify(mem_r[idx]);
        aud_sub[56*k +: 56] = {^r24, 3'b000, ^l24, 3'b000, r24, l24};
        present[k] = 1'b1;
        bflag[k]   = (fc == 8'd0);
      end
    end
    aud_header = {bflag, 4'b0000, 4'b0000, present, 8'h02};
    frame_sum  = {1'b0, frame} + {6'b000000, pop_n};
    frame_next = (frame_sum >= 9'd192) ? 8'(frame_sum - 9'd192) : frame_sum[7:0];
  end

  always_ff @(posedge clk_pixel) begin
    if (push_ok) begin
      mem_l[wr_ptr] <= audio_sample_l;
      mem_r[wr_ptr] <= audio_sample_r;
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      frame         <= 8'd0;
      fifo_overflow <= 1'b0;
    end else begin
      rd_ptr <= rd_ptr + PTR_W'(pop_n);
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      count  <= count + CNT_W'(push_ok) - CNT_W'(pop_n);
      frame  <= frame_next;
      if (audio_sample_valid && !push_ok) fifo_overflow <= 1'b1;
    end
  end

  // An acr_wrap edge in the selection cycle re-arms the request
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      acr_wrap_q <= 1'b0;
      acr_pend   <= 1'b0;
      avi_pend   <= 1'b0;
    end else begin
      acr_wrap_q <= acr_wrap;
      acr_pend   <= (acr_pend & ~sel_acr) | (acr_wrap ^ acr_wrap_q);
      avi_pend   <= (avi_pend & ~sel_avi) | video_field_end;
    end
  end

`ifdef AUDIO_INFOFRAME_EN
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) aif_pend <= 1'b0;
    else          aif_pend <= (aif_pend & ~sel_aif) | video_field_end;
  end
`else
  assign aif_pend = 1'b0;
  logic unused_aif;
  assign unused_aif = ^{aif_header, aif_sub, sel_aif};
`endif

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      header      <= 24'd0;
      sub         <= '0;
      packet_type <= PT_NULL;
    end else if (packet_enable) begin
      if (sel_acr) begin
        header      <= acr_header;
        sub         <= acr_sub;
        packet_type <= PT_ACR;
      end else if (sel_audio) begin
        header      <= aud_header;
        sub         <= aud_sub;
        packet_type <= PT_AUDIO;
      end else if (sel_avi) begin
        header      <= avi_header;
        sub         <= avi_sub;
        packet_type <= PT_AVI;
`ifdef AUDIO_INFOFRAME_EN
      end else if (sel_aif) begin
        header      <= aif_header;
        sub         <= aif_sub;
        packet_type <= PT_AIF;
`endif
      end else begin
        header      <= 24'd0;
        sub         <= '0;
        packet_type <= PT_NULL;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hdmi_packet_scheduler.sv
`default_nettype none
// Testbench for hdmi_packet_scheduler: behavioural model + scoreboard plus
// a vector table for the arbitration order.
module tb_hdmi_packet_scheduler;

  localparam int W     = 16;
  localparam int DEPTH = 8;
`ifdef AUDIO_INFOFRAME_EN
  localparam bit AIF_EN = 1'b1;
`else
  localparam bit AIF_EN = 1'b0;
`endif

  logic           clk_pixel = 1'b0;
  logic           reset_n;
  logic           audio_sample_valid;
  logic [W-1:0]   audio_sample_l;
  logic [W-1:0]   audio_sample_r;
  logic           acr_wrap;
  logic [23:0]    acr_header;
  logic [223:0]   acr_sub;
  logic [23:0]    avi_header;
  logic [223:0]   avi_sub;
  logic [23:0]    aif_header;
  logic [223:0]   aif_sub;
  logic           video_field_end;
  logic           packet_enable;
  logic [23:0]    header;
  logic [223:0]   sub;
  logic [2:0]     packet_type;
  logic           fifo_overflow;

  always #5 clk_pixel = ~clk_pixel;

  hdmi_packet_scheduler #(.AUDIO_BIT_WIDTH(W), .FIFO_DEPTH(DEPTH)) dut (
    .clk_pixel(clk_pixel), .reset_n(reset_n),
    .audio_sample_valid(audio_sample_valid),
    .audio_sample_l(audio_sample_l), .audio_sample_r(audio_sample_r),
    .acr_wrap(acr_wrap), .acr_header(acr_header), .acr_sub(acr_sub),
    .avi_header(avi_header), .avi_sub(avi_sub),
    .aif_header(aif_header), .aif_sub(aif_sub),
    .video_field_end(video_field_end), .packet_enable(packet_enable),
    .header(header), .sub(sub), .packet_type(packet_type),
    .fifo_overflow(fifo_overflow)
  );

  typedef struct {
    logic [23:0]  header;
    logic [223:0] sub;
    logic [2:0]   ptype;
  } pkt_t;

  typedef struct {
    bit         push;
    bit         tog;
    bit         fe;
    bit         pe;
    logic [2:0] exp_type;
  } vec_t;

  pkt_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  logic [W-1:0] m_l[$];
  logic [W-1:0] m_r[$];
  bit   m_acr_pend, m_avi_pend, m_aif_pend, m_acr_prev;
  int   m_frame;
  int   samp_no;
  int   bpos[$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_l.delete(); m_r.delete(); exp_q.delete(); bpos.delete();
    m_acr_pend = 0; m_avi_pend = 0; m_aif_pend = 0; m_acr_prev = 0;
    m_frame = 0; samp_no = 0;
  endtask

  task automatic model_select(output pkt_t p);
    int n;
    logic [3:0] b, pres;
    logic [23:0] l24, r24;
    p.header = '0; p.sub = '0; p.ptype = 3'd0;
    b = 4'h0; pres = 4'h0;
    if (m_acr_pend) begin
      p.header = acr_header; p.sub = acr_sub; p.ptype = 3'd1;
      m_acr_pend = 0;
    end else if (m_l.size() > 0) begin
      n = (m_l.size() > 4) ? 4 : m_l.size();
      for (int k = 0; k < n; k++) begin
        l24 = 24'(m_l.pop_front()) << (24 - W);
        r24 = 24'(m_r.pop_front()) << (24 - W);
        p.sub[56*k +: 56] = {^r24, 3'b000, ^l24, 3'b000, r24, l24};
        pres[k] = 1'b1;
        if (m_frame == 0) b[k] = 1'b1;
        m_frame = (m_frame + 1) % 192;
      end
      p.header = {b, 4'h0, 4'h0, pres, 8'h02};
      p.ptype  = 3'd2;
    end else if (m_avi_pend) begin
      p.header = avi_header; p.sub = avi_sub; p.ptype = 3'd3;
      m_avi_pend = 0;
    end else if (AIF_EN && m_aif_pend) begin
      p.header = aif_header; p.sub = aif_sub; p.ptype = 3'd4;
      m_aif_pend = 0;
    end
  endtask

  // One clock: drive, update model, sample #1 after the edge, compare slot output
  task automatic cycle(input bit push, input logic [W-1:0] l, input logic [W-1:0] r,
                       input bit tog, input bit fe, input bit pe);
    pkt_t p;
    bit full, popped;
    audio_sample_valid = push; audio_sample_l = l; audio_sample_r = r;
    video_field_end = fe; packet_enable = pe;
    if (tog) acr_wrap = ~acr_wrap;
    full   = (m_l.size() == DEPTH);
    popped = 0;
    if (pe) begin
      popped = !m_acr_pend && (m_l.size() > 0);
      model_select(p);
      exp_q.push_back(p);
    end
    if (acr_wrap != m_acr_prev) m_acr_pend = 1;
    m_acr_prev = acr_wrap;
    if (fe) begin
      m_avi_pend = 1;
      if (AIF_EN) m_aif_pend = 1;
    end
    if (push && !(full && !popped)) begin
      m_l.push_back(l); m_r.push_back(r);
    end
    @(posedge clk_pixel); #1;
    if (pe) begin
      p = exp_q.pop_front();
      check("slot_type",   packet_type, p.ptype);
      check("slot_header", header, p.header);
      check("slot_sub",    sub, p.sub);
      if (packet_type == 3'd2) begin
        for (int k = 0; k < 4; k++) begin
          if (header[8+k]) begin
            samp_no++;
            if (header[20+k]) bpos.push_back(samp_no);
          end
        end
      end
    end
    audio_sample_valid = 0; video_field_end = 0; packet_enable = 0;
  endtask

  task automatic slot();
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic idle();
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk_pixel); #1;
    reset_n = 0; acr_wrap = 0;
    audio_sample_valid = 0; video_field_end = 0; packet_enable = 0;
    repeat (2) @(posedge clk_pixel);
    #1;
    model_reset();
    reset_n = 1;
  endtask

  vec_t tbl [9];

  initial begin
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd1};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd2};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd3};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b1, AIF_EN ? 3'd4 : 3'd0};

    reset_n = 0; acr_wrap = 0;
    audio_sample_valid = 0; audio_sample_l = '0; audio_sample_r = '0;
    video_field_end = 0; packet_enable = 0;
    acr_header = 24'h000001; acr_sub = {7{32'hA5A5_0001}};
    avi_header = 24'h0D0282; avi_sub = {7{32'h1357_9BDF}};
    aif_header = 24'h0A0184; aif_sub = {7{32'h2468_ACE0}};
    model_reset();

    // Reset held: a slot pulse must not leave Null
    repeat (2) @(posedge clk_pixel);
    #1 packet_enable = 1;
    @(posedge clk_pixel); #1;
    packet_enable = 0;
    check("rst_header", header, 24'h0);
    check("rst_sub", sub, 224'h0);
    check("rst_type", packet_type, 3'd0);
    check("rst_ovf", fifo_overflow, 1'b0);
    reset_n = 1;
    slot();

    // ACR: single request, coalesced edges, edge during selection
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    slot();
    check("acr_header", header, 24'h000001);
    check("acr_type", packet_type, 3'd1);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    acr_sub = {7{32'h0BAD_F00D}};
    slot();
    slot();
    check("acr_coalesce", packet_type, 3'd0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    slot();
    check("acr_rearm", packet_type, 3'd1);

    // Reset in the middle of an ACR packet returns to Null at once
    #2 reset_n = 0;
    #1;
    check("midrst_type", packet_type, 3'd0);
    check("midrst_header", header, 24'h0);
    @(posedge clk_pixel); #1;
    model_reset(); acr_wrap = 0;
    reset_n = 1;

    // Audio packets: 6 pairs over 2 slots
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, 16'h1234, 16'h8001, 1'b0, 1'b0, 1'b0);
    slot();
    check("aud_hb0", header[7:0], 8'h02);
    check("aud_hb1_first", header[15:8], 8'h0F);
    check("aud_sub0_l", sub[23:0], 24'h123400);
    check("aud_pl", sub[51], 1'b1);
    check("aud_pr", sub[55], 1'b0);
    slot();
    check("aud_hb1_second", header[15:8], 8'h03);

    // Arbitration order from the vector table
    do_reset();
    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].push, 16'hA000 | 16'(i), 16'h5000 | 16'(i), tbl[i].tog, tbl[i].fe, tbl[i].pe);
      if (tbl[i].pe) check("arb_order", packet_type, tbl[i].exp_type);
    end

    // IEC frame counter: 193 pairs, B only on samples 1 and 193
    do_reset();
    for (int i = 0; i < 193; i++)
      cycle(1'b1, 16'(i), ~16'(i), 1'b0, 1'b0, (i % 3) == 2);
    for (int j = 0; j < 20; j++)
      if (m_l.size() > 0) slot();
    check("b_count", bpos.size(), 2);
    check("b_first", (bpos.size() > 0) ? bpos[0] : 0, 1);
    check("b_second", (bpos.size() > 1) ? bpos[1] : 0, 193);
    check("samples_out", samp_no, 193);

    // Overflow: 9th push with no slot is dropped
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 16'h0100 + 16'(i), 16'h0200 + 16'(i), 1'b0, 1'b0, 1'b0);
    check("ovf_full_clear", fifo_overflow, 1'b0);
    cycle(1'b1, 16'hDEAD, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    check("ovf_set", fifo_overflow, 1'b1);
    repeat (3) slot();
    check("ovf_sticky", fifo_overflow, 1'b1);

    // Push on a full FIFO in a slot cycle is accepted
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 16'h0300 + 16'(i), 16'h0400 + 16'(i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'hCAFE, 16'hF00D, 1'b0, 1'b0, 1'b1);
    check("full_push_no_ovf", fifo_overflow, 1'b0);
    repeat (3) slot();
    check("full_push_drained", packet_type, 3'd0);
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
